fifo_deq_serializer: RTL

- Reader-side companion to the team's depth-1 FIFO.
- Drains wide words from an upstream FIFO dequeue interface (EMPTY_N / D_OUT / DEQ) and replays each word as narrower beats into a downstream FIFO enqueue interface (FULL_N / D_IN / ENQ).
- Sits between a wide datapath FIFO and a narrow link or FIFO, for example a 32-bit worker output feeding an 8-bit port.
- Sustains full throughput: one beat per cycle with no bubble between consecutive words.

---
 rtl/fifo_pkg.sv | 51 +++++
 rtl/fifo_deq_serializer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg: shared definitions for the FIFO width-converter family
// (fifo_deq_serializer today, fifo_enq_deserializer next).
//
// Contents:
//   fifo_state_e     - holding-register state encoding (ST_EMPTY / ST_LOADED)
//   clog2()          - constant ceil(log2) for sizing counters
//   width_ratio()    - wide/narrow width ratio
//   cnt_width()      - beat counter width for a given ratio (never below 1)
//   `FIFO_WIDTH_CHECK(IW, OW)
//                    - elaboration guard: IW must be an exact multiple of OW
//                      with a ratio of at least 2. Use it at module scope.
// -----------------------------------------------------------------------------
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_WIDTH_CHECK(IW, OW) \
  if (((OW) < 1) || (((IW) % (OW)) != 0) || (((IW) / (OW)) < 2)) begin : g_width_check \
    $error("fifo width converter: in_width=%0d must be a multiple of out_width=%0d with ratio >= 2", (IW), (OW)); \
  end

package fifo_pkg;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } fifo_state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int width_ratio(input int iw, input int ow);
    return (ow > 0) ? (iw / ow) : 0;
  endfunction

  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : clog2(ratio);
  endfunction

endpackage

`endif

// File: rtl/fifo_deq_serializer.sv
// -----------------------------------------------------------------------------
// fifo_deq_serializer
//
// Pulls wide words from an upstream FIFO dequeue port and replays each one as
// in_width/out_width narrow beats into a downstream FIFO enqueue port. A new
// word is dequeued in the same cycle the last beat of the current one is
// enqueued, so back-to-back words stream at one beat per cycle.
//
// Parameters:
//   in_width   upstream word width (default 32)
//   out_width  downstream beat width (default 8); in_width must be an exact
//              multiple with ratio >= 2
//
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous active-high reset (priority over CLR)
//   CLR          synchronous flush of the held word and beat count
//   SRC_EMPTY_N  upstream has a word
//   SRC_D_OUT    upstream head word
//   SRC_DEQ      dequeue strobe to upstream
//   DST_FULL_N   downstream can accept a beat
//   DST_D_IN     current beat
//   DST_ENQ      enqueue strobe to downstream
//   BUSY         a word is held
//
// Build option:
//   FIFO_DEQ_SERIALIZER_MSB_FIRST_EN - when defined, the most-significant slice
//   of each word is sent first; otherwise least-significant first.
// -----------------------------------------------------------------------------
module fifo_deq_serializer
  import fifo_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int out_width = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 SRC_EMPTY_N,
  input  logic [in_width-1:0]  SRC_D_OUT,
  output logic                 SRC_DEQ,
  input  logic                 DST_FULL_N,
  output logic [out_width-1:0] DST_D_IN,
  output logic                 DST_ENQ,
  output logic                 BUSY
);

  `FIFO_WIDTH_CHECK(in_width, out_width)

  localparam int RATIO = width_ratio(in_width, out_width);
  localparam int CNT_W = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  fifo_state_e state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [in_width-1:0] hold_reg;
  logic load;
  logic last;

  // Held word viewed as an array of beats, element 0 = least-significant slice.
  logic [RATIO-1:0][out_width-1:0] slices;
  logic [CNT_W-1:0] sel;

  assign last   = (beat_cnt == LAST_BEAT);
  assign slices = hold_reg;

`ifdef FIFO_DEQ_SERIALIZER_MSB_FIRST_EN
  assign sel = LAST_BEAT - beat_cnt;
`else
  assign sel = beat_cnt;
`endif

  assign DST_D_IN = slices[sel];

  // RST gates the strobes combinationally so nothing moves in the reset cycle,
  // even if a word was held going in.
  always_comb begin
    SRC_DEQ = 1'b0;
    DST_ENQ = 1'b0;
    BUSY    = 1'b0;
    if (!RST) begin
      BUSY    = (state == ST_LOADED);
      DST_ENQ = (state == ST_LOADED) && DST_FULL_N && !CLR;
      SRC_DEQ = SRC_EMPTY_N && !CLR &&
                ((state == ST_EMPTY) || (last && DST_FULL_N));
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    load         = 1'b0;
    if (CLR) begin
      state_nxt    = ST_EMPTY;
      beat_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (SRC_DEQ) begin
            state_nxt    = ST_LOADED;
            beat_cnt_nxt = '0;
            load         = 1'b1;
          end
        end
        ST_LOADED: begin
          if (DST_ENQ) begin
            if (!last) begin
              beat_cnt_nxt = beat_cnt + 1'b1;
            end else if (SRC_DEQ) begin
              // zero-bubble hand-over to the next word
              beat_cnt_nxt = '0;
              load         = 1'b1;
            end else begin
              state_nxt    = ST_EMPTY;
              beat_cnt_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt    = ST_EMPTY;
          beat_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_EMPTY;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Data register carries no reset; load is already suppressed under RST.
  always_ff @(posedge CLK) begin
    if (load) hold_reg <= SRC_D_OUT;
  end

endmodule
